// File: rtl/codec_mm_slave.sv
// codec_mm_slave: Avalon-MM slave between the system bus and the WM8731
// audio datapath. It provides an I2C command register, a status word,
// DAC/ADC sample FIFOs with waitrequest back-pressure, and burst tracking.
// Optional feature macro: CODEC_MM_SLAVE_IRQ_EN builds the IRQ flag/mask
// registers and drives slave_irq; without it, slave_irq is tied low.
module codec_mm_slave #(
  parameter int DATA_W  = 32,
  parameter int FIFO_AW = 3,
  parameter int TX_LOW  = 2,
  parameter int RX_HIGH = 6
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              slave_chipselect,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [2:0]        slave_address,
  input  logic [DATA_W-1:0] slave_writedata,
  output logic [DATA_W-1:0] slave_readdata,
  output logic              slave_waitrequest,
  input  logic              slave_beginbursttransfer,
  input  logic [7:0]        slave_burstcount,
  output logic              slave_irq,
  output logic [23:0]       i2c_packet,
  output logic              i2c_start,
  input  logic              i2c_idle,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  input  logic              dac_ready,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid
);

  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RBURST = 2'd1;
  localparam logic [1:0] ST_WBURST = 2'd2;

  localparam logic [FIFO_AW:0] TX_LOW_L  = (FIFO_AW+1)'(TX_LOW);
  localparam logic [FIFO_AW:0] RX_HIGH_L = (FIFO_AW+1)'(RX_HIGH);

  // Burst tracking state
  logic [1:0] state_q, state_d;
  logic [7:0] bcnt_q, bcnt_d;
  logic [2:0] baddr_q, baddr_d;
  logic [7:0] cnt_eff;
  logic       burst_go;

  // Bus decode
  logic [2:0] addr_eff;
  logic       rd_req, wr_req, wait_c, rd_acc, wr_acc, beat_acc;

  // TX (DAC) FIFO
  logic [DATA_W-1:0]  tx_mem [DEPTH];
  logic [FIFO_AW:0]   tx_wp_q, tx_rp_q, tx_level;
  logic               tx_empty, tx_full, tx_push, tx_pop;

  // RX (ADC) FIFO
  logic [DATA_W-1:0]  rx_mem [DEPTH];
  logic [FIFO_AW:0]   rx_wp_q, rx_rp_q, rx_level;
  logic               rx_empty, rx_full, rx_push, rx_pop, rx_drop;
  logic [DATA_W-1:0]  rx_head;

  // I2C command and sticky overrun status
  logic [23:0] i2c_pkt_q;
  logic        i2c_start_q, i2c_cmd_wr;
  logic        ovr_q;

  logic        tx_low_c, rx_high_c;
  logic [19:0] status_c;

  // During a burst the address latched on the first beat steers every beat,
  // so FIFO streaming keeps hitting the same port.
  assign addr_eff = (state_q == ST_IDLE) ? slave_address : baddr_q;
  assign rd_req   = slave_chipselect & slave_read;
  assign wr_req   = slave_chipselect & slave_write;

  // Waitrequest: I2C command while the master is busy, DAC push while TX is
  // full with no pop this cycle, ADC pop while RX is empty.
  always_comb begin
    wait_c = 1'b0;
    if (wr_req) begin
      case (addr_eff)
        3'd0:    wait_c = !i2c_idle;
        3'd2:    wait_c = tx_full & !tx_pop;
        default: wait_c = 1'b0;
      endcase
    end
    if (rd_req && addr_eff == 3'd3)
      wait_c = wait_c | rx_empty;
  end

  assign slave_waitrequest = wait_c;
  assign rd_acc   = rd_req & !wait_c;
  assign wr_acc   = wr_req & !wait_c;
  assign beat_acc = rd_acc | wr_acc;

  // FIFO levels and flags; the extra pointer MSB separates full from empty.
  assign tx_level = tx_wp_q - tx_rp_q;
  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = tx_level[FIFO_AW];
  assign rx_level = rx_wp_q - rx_rp_q;
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = rx_level[FIFO_AW];

  assign tx_pop   = !tx_empty & dac_ready;
  assign tx_push  = wr_acc & (addr_eff == 3'd2);
  assign rx_pop   = rd_acc & (addr_eff == 3'd3);
  // A full RX still takes a sample when the bus pops in the same cycle.
  assign rx_push  = adc_valid & (!rx_full | rx_pop);
  assign rx_drop  = adc_valid & rx_full & !rx_pop;

  assign dac_valid = !tx_empty;
  assign dac_data  = tx_empty ? '0 : tx_mem[tx_rp_q[FIFO_AW-1:0]];
  assign rx_head   = rx_mem[rx_rp_q[FIFO_AW-1:0]];

  assign i2c_cmd_wr = wr_acc & (addr_eff == 3'd0);
  assign i2c_packet = i2c_pkt_q;
  assign i2c_start  = i2c_start_q;

  assign tx_low_c  = (tx_level <= TX_LOW_L);
  assign rx_high_c = (rx_level >= RX_HIGH_L);

  assign status_c = {8'(rx_level), 8'(tx_level), ovr_q, rx_empty, tx_full, i2c_idle};

  // FIFO storage holds data only; the pointers alone define occupancy.
  always_ff @(posedge Clk) begin
    if (tx_push) tx_mem[tx_wp_q[FIFO_AW-1:0]] <= slave_writedata;
    if (rx_push) rx_mem[rx_wp_q[FIFO_AW-1:0]] <= adc_data;
  end

  // FIFO pointers, I2C command register and sticky overrun status.
  always_ff @(posedge Clk or posedge Rst_n) begin
    if (Rst_n) begin
      tx_wp_q     <= '0;
      tx_rp_q     <= '0;
      rx_wp_q     <= '0;
      rx_rp_q     <= '0;
      i2c_pkt_q   <= '0;
      i2c_start_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      if (i2c_cmd_wr) i2c_pkt_q <= slave_writedata[23:0];
      i2c_start_q <= i2c_cmd_wr;
      if (rx_drop) ovr_q <= 1'b1;
    end
  end

  // Burst FSM: a begin in IDLE loads the beat count (0 counts as 1); the
  // beat accepted with a count of one returns to IDLE, even on the first beat.
  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    baddr_d  = baddr_q;
    cnt_eff  = bcnt_q;
    burst_go = 1'b0;
    if (state_q != ST_IDLE && state_q != ST_RBURST && state_q != ST_WBURST)
      state_d = ST_IDLE;
    if (state_q == ST_IDLE && slave_chipselect && slave_beginbursttransfer &&
        (slave_read || slave_write)) begin
      burst_go = 1'b1;
      cnt_eff  = (slave_burstcount == 8'd0) ? 8'd1 : slave_burstcount;
      baddr_d  = slave_address;
      state_d  = slave_read ? ST_RBURST : ST_WBURST;
      bcnt_d   = cnt_eff;
    end
    if ((state_q == ST_RBURST || state_q == ST_WBURST || burst_go) && beat_acc) begin
      if (cnt_eff == 8'd1) state_d = ST_IDLE;
      else                 bcnt_d  = cnt_eff - 8'd1;
    end
  end

  // Burst state register; reset abandons any burst in progress.
  always_ff @(posedge Clk or posedge Rst_n) begin
    if (Rst_n) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      baddr_q <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      baddr_q <= baddr_d;
    end
  end

`ifdef CODEC_MM_SLAVE_IRQ_EN
  logic [3:0] flags_q, flags_d, mask_q, mask_d, set_c;
  logic       idle_q;

  assign set_c = {rx_drop, i2c_idle & ~idle_q, rx_high_c, tx_low_c};

  // Sticky flags with write-one-to-clear; a new set beats a same-cycle clear.
  always_comb begin
    flags_d = flags_q;
    mask_d  = mask_q;
    if (wr_acc && addr_eff == 3'd4) flags_d = flags_q & ~slave_writedata[3:0];
    if (wr_acc && addr_eff == 3'd5) mask_d  = slave_writedata[3:0];
    flags_d = flags_d | set_c;
  end

  // IRQ flag, mask and I2C idle edge-detect registers.
  always_ff @(posedge Clk or posedge Rst_n) begin
    if (Rst_n) begin
      flags_q <= '0;
      mask_q  <= '0;
      idle_q  <= 1'b0;
    end else begin
      flags_q <= flags_d;
      mask_q  <= mask_d;
      idle_q  <= i2c_idle;
    end
  end

  assign slave_irq = |(flags_q & mask_q);
`else
  // Threshold comparators have no consumer without the IRQ block.
  logic unused_irq_src;
  assign unused_irq_src = &{1'b0, tx_low_c, rx_high_c};
  assign slave_irq = 1'b0;
`endif

  // Read mux; an idle or unselected bus reads as zero.
  always_comb begin
    slave_readdata = '0;
    if (rd_req) begin
      case (addr_eff)
        3'd0: slave_readdata[23:0] = i2c_pkt_q;
        3'd1: slave_readdata[19:0] = status_c;
        3'd3: slave_readdata       = rx_head;
`ifdef CODEC_MM_SLAVE_IRQ_EN
        3'd4: slave_readdata[3:0]  = flags_q;
        3'd5: slave_readdata[3:0]  = mask_q;
`endif
        default: slave_readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_mm_slave.sv
// Testbench for codec_mm_slave: directed bus/stream stimulus with a
// scoreboard of expected read data, DAC samples and I2C packets.
module tb_codec_mm_slave;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        waitreq;
  logic        bbeg = 1'b0;
  logic [7:0]  bcount = '0;
  logic        irq;
  logic [23:0] i2c_pkt;
  logic        i2c_start;
  logic        i2c_idle = 1'b1;
  logic [31:0] dac_data;
  logic        dac_valid;
  logic        dac_ready = 1'b0;
  logic [31:0] adc_data = '0;
  logic        adc_valid = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int w;
  int wsum;

  logic [31:0] rdq[$];
  logic [31:0] dacq[$];
  logic [23:0] i2cq[$];

  codec_mm_slave #(.DATA_W(32), .FIFO_AW(3), .TX_LOW(2), .RX_HIGH(6)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .slave_chipselect(cs), .slave_read(rd), .slave_write(wr),
    .slave_address(addr), .slave_writedata(wdata), .slave_readdata(rdata),
    .slave_waitrequest(waitreq),
    .slave_beginbursttransfer(bbeg), .slave_burstcount(bcount),
    .slave_irq(irq),
    .i2c_packet(i2c_pkt), .i2c_start(i2c_start), .i2c_idle(i2c_idle),
    .dac_data(dac_data), .dac_valid(dac_valid), .dac_ready(dac_ready),
    .adc_data(adc_data), .adc_valid(adc_valid)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge Clk); #1;
  endtask

  // One bus access; returns the number of waitrequest cycles seen.
  task automatic access(input bit is_wr, input logic [2:0] a, input logic [31:0] d,
                        input int maxwait, output int waited);
    bit timed_out;
    cs = 1'b1; rd = !is_wr; wr = is_wr; addr = a; wdata = d;
    waited = 0;
    timed_out = 1'b0;
    @(negedge Clk);
    while (waitreq) begin
      if (waited >= maxwait) begin timed_out = 1'b1; break; end
      @(posedge Clk); #1;
      bbeg = 1'b0;
      waited++;
      @(negedge Clk);
    end
    @(posedge Clk); #1;
    cs = 1'b0; rd = 1'b0; wr = 1'b0; bbeg = 1'b0;
    if (timed_out) begin
      n_tests++;
      n_fail++;
      $display("FAIL access_timeout: addr %0d waited %0d, limit %0d", a, waited, maxwait);
      if (!is_wr && rdq.size() > 0) void'(rdq.pop_front());
    end
  endtask

  // Monitor: compares every accepted read, DAC handshake and I2C start.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        if (cs && rd && !waitreq) begin
          if (rdq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL rd_unexpected: got 0x%08h, expected no read", rdata);
          end else begin
            e = rdq.pop_front();
            chk("readdata", rdata, e);
          end
        end
        if (dac_valid && dac_ready) begin
          if (dacq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL dac_unexpected: got 0x%08h, expected no sample", dac_data);
          end else begin
            e = dacq.pop_front();
            chk("dac_data", dac_data, e);
          end
        end
        if (i2c_start) begin
          if (i2cq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL i2c_unexpected: got 0x%06h, expected no start", i2c_pkt);
          end else begin
            e = {8'h00, i2cq.pop_front()};
            chk("i2c_packet", {8'h00, i2c_pkt}, e);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_waitreq",   {31'd0, waitreq},   32'd0);
    chk("rst_irq",       {31'd0, irq},       32'd0);
    chk("rst_dac_valid", {31'd0, dac_valid}, 32'd0);
    chk("rst_i2c_start", {31'd0, i2c_start}, 32'd0);
    chk("rst_i2c_pkt",   {8'd0, i2c_pkt},    32'd0);
    chk("rst_dac_data",  dac_data,           32'd0);
    chk("rst_readdata",  rdata,              32'd0);
    sync();
    Rst_n = 1'b0;
    sync();
    rdq.push_back(32'h5);
    access(1'b0, 3'd1, 32'd0, 5, w);

    // I2C command with master idle: single-cycle start pulse
    i2cq.push_back(24'h00341A);
    access(1'b1, 3'd0, 32'h0000341A, 5, w);
    chk("i2c_idle_nowait", 32'(w), 32'd0);
    @(negedge Clk); @(negedge Clk);
    chk("i2c_start_width", {31'd0, i2c_start}, 32'd0);
    sync();

    // I2C command while busy: held until idle rises
    i2c_idle = 1'b0;
    i2cq.push_back(24'h005A5A);
    fork
      access(1'b1, 3'd0, 32'h00005A5A, 20, w);
      begin repeat (4) @(posedge Clk); #1; i2c_idle = 1'b1; end
    join
    chk("i2c_wait_cycles", 32'(w), 32'd4);
    rdq.push_back(32'h00005A5A);
    access(1'b0, 3'd0, 32'd0, 5, w);

    // DAC burst of 9 into an 8-deep FIFO with the sink stalled
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      dacq.push_back(32'hD000_0000 + i);
      if (i == 0) begin bbeg = 1'b1; bcount = 8'd9; end
      access(1'b1, 3'd2, 32'hD000_0000 + i, 0, w);
      wsum += w;
    end
    chk("dac_8_nowait", 32'(wsum), 32'd0);
    dacq.push_back(32'hD000_0008);
    fork
      access(1'b1, 3'd2, 32'hD000_0008, 20, w);
      begin repeat (3) @(posedge Clk); #1; dac_ready = 1'b1; end
    join
    chk("dac_9th_wait", 32'(w), 32'd3);
    repeat (12) sync();
    chk("dac_drained", 32'(dacq.size()), 32'd0);

    // ADC read on empty RX completes once a sample arrives
    rdq.push_back(32'h0000A5A5);
    fork
      access(1'b0, 3'd3, 32'd0, 20, w);
      begin
        repeat (2) @(posedge Clk); #1;
        adc_data = 32'h0000A5A5; adc_valid = 1'b1;
        @(posedge Clk); #1;
        adc_valid = 1'b0;
      end
    join
    chk("adc_wait_seen", 32'(w > 0), 32'd1);
    rdq.push_back(32'h5);
    access(1'b0, 3'd1, 32'd0, 5, w);

    // Nine ADC strobes with no reads: 8 stored, one dropped
    adc_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      adc_data = 32'h100 + i;
      sync();
    end
    adc_valid = 1'b0;
    rdq.push_back(32'h0000_8009);
    access(1'b0, 3'd1, 32'd0, 5, w);

`ifdef CODEC_MM_SLAVE_IRQ_EN
    access(1'b1, 3'd5, 32'h8, 5, w);
    @(negedge Clk);
    chk("irq_overrun", {31'd0, irq}, 32'd1);
    sync();
    rdq.push_back(32'hF);
    access(1'b0, 3'd4, 32'd0, 5, w);
    access(1'b1, 3'd4, 32'h8, 5, w);
    @(negedge Clk);
    chk("irq_w1c", {31'd0, irq}, 32'd0);
    sync();
    rdq.push_back(32'h7);
    access(1'b0, 3'd4, 32'd0, 5, w);
`else
    access(1'b1, 3'd5, 32'hF, 5, w);
    @(negedge Clk);
    chk("irq_tied_low", {31'd0, irq}, 32'd0);
    sync();
    rdq.push_back(32'h0);
    access(1'b0, 3'd4, 32'd0, 5, w);
    rdq.push_back(32'h0);
    access(1'b0, 3'd5, 32'd0, 5, w);
`endif

    // Drain RX in order; overrun stays sticky
    for (int i = 0; i < 8; i++) begin
      rdq.push_back(32'h100 + i);
      access(1'b0, 3'd3, 32'd0, 5, w);
    end
    rdq.push_back(32'hD);
    access(1'b0, 3'd1, 32'd0, 5, w);

    // Unmapped address
    access(1'b1, 3'd6, 32'hFFFF_FFFF, 0, w);
    chk("addr6_nowait", 32'(w), 32'd0);
    rdq.push_back(32'h0);
    access(1'b0, 3'd6, 32'd0, 5, w);

    // Burstcount 0 is one beat; next access decodes its own address
    dacq.push_back(32'h0000BEEF);
    bbeg = 1'b1; bcount = 8'd0;
    access(1'b1, 3'd2, 32'h0000BEEF, 5, w);
    rdq.push_back(32'h1D);
    access(1'b0, 3'd1, 32'd0, 5, w);
    repeat (3) sync();
    chk("beef_drained", 32'(dacq.size()), 32'd0);

    // Reset in the middle of a write burst
    dac_ready = 1'b0;
    bbeg = 1'b1; bcount = 8'd6;
    for (int i = 0; i < 3; i++) access(1'b1, 3'd2, 32'hC0 + i, 5, w);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("midrst_dac_valid", {31'd0, dac_valid}, 32'd0);
    repeat (2) sync();
    Rst_n = 1'b0;
    @(negedge Clk);
    chk("postrst_dac_valid", {31'd0, dac_valid}, 32'd0);
    chk("postrst_dac_data",  dac_data,           32'd0);
    chk("postrst_i2c_pkt",   {8'd0, i2c_pkt},    32'd0);
    sync();
    rdq.push_back(32'h5);
    access(1'b0, 3'd1, 32'd0, 5, w);

    repeat (3) sync();
    chk("rdq_empty",  32'(rdq.size()),  32'd0);
    chk("dacq_empty", 32'(dacq.size()), 32'd0);
    chk("i2cq_empty", 32'(i2cq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
